round_ko_sequencer: RTL and testbench
=====================================

// Module: round_ko_sequencer
// PURPOSE
//  Owns both fighters' health and sequences each round: READY -> FIGHT -> DRAIN -> KO_FLASH -> ROUND_END.
//  Accepts damage pulses from each fighter's hit logic and drives curr_health_l/r into the status-bar renderer.
//  Reads back the renderer's animated final_health_l/r, and drives the KO banner and player freeze.
//  Sits between the combat logic and the status-bar graphics, in the clk (100 MHz) domain.
// PARAMETERS
//  MAX_HEALTH      9'd300      health loaded at reset / round start
//  TICK_DIV        5_000_000   clk cycles per animation tick (20 Hz @ 100 MHz)
//  DRAIN_MAX_TICKS 40          DRAIN timeout in ticks
//  KO_FLASH_TICKS  20          ticks of KO flashing
//  WINS_TO_MATCH   2'd2        round wins that end the match
// PORTS
//  clk            in   1  system clock
//  reset          in   1  synchronous, active-high reset
//  round_start    in   1  1-cycle pulse: start/next round
//  hit_l          in   1  1-cycle pulse: left fighter takes hit_dmg_l
//  hit_dmg_l      in   9  damage to left fighter, sampled with hit_l
//  hit_r          in   1  1-cycle pulse: right fighter takes hit_dmg_r
//  hit_dmg_r      in   9  damage to right fighter, sampled with hit_r
//  final_health_l in   9  animated left health from status bar
//  final_health_r in   9  animated right health from status bar
//  curr_health_l  out  9  target left health to status bar
//  curr_health_r  out  9  target right health to status bar
//  hit_accept_l   out  1  pulse, cycle after an accepted hit_l
//  hit_accept_r   out  1  pulse, cycle after an accepted hit_r
//  freeze         out  1  1 = fighters' inputs ignored
//  ko_show        out  1  KO banner enable (flashes)
//  round_over     out  1  high in ROUND_END
//  winner         out  2  00 none, 01 left won, 10 right won, 11 double KO
//  wins_l         out  2  rounds won by left fighter
//  wins_r         out  2  rounds won by right fighter
//  match_over     out  1  either wins_x == WINS_TO_MATCH
// BEHAVIOUR
//  Reset (sync, active-high):
//   - state = READY; health = MAX_HEALTH; freeze = 1.
//   - ko_show, round_over, accepts, match_over = 0; winner, wins = 0; tick counter = 0.
//  Tick: free-running counter 0..TICK_DIV-1; tick pulses for one cycle at TICK_DIV-1.
//  READY:
//   - round_start -> FIGHT next cycle, freeze = 0.
//   - Hits are ignored.
//  FIGHT:
//   - A hit pulse subtracts its damage next cycle, saturating at 0 (dmg >= health -> 0).
//   - The matching accept pulses in that same cycle.
//   - hit_l and hit_r in the same cycle are both applied in that cycle.
//   - dmg = 0 is accepted with no change.
//   - round_start is ignored.
//   - When either health reaches 0 -> DRAIN in the cycle after the update; freeze = 1.
//  Outside FIGHT: hit pulses are dropped and no accept is issued.
//  DRAIN:
//   - Waits for final_health_l == curr_health_l AND final_health_r == curr_health_r.
//   - Also exits on DRAIN_MAX_TICKS ticks.
//   - Either condition -> KO_FLASH, with tick count cleared.
//  KO_FLASH:
//   - ko_show = 1 on entry, then toggles on every tick.
//   - After KO_FLASH_TICKS ticks -> ROUND_END with ko_show = 1 (steady).
//  ROUND_END entry (one cycle), latching winner:
//   - l==0 && r==0 -> 11, no win counted.
//   - r==0 -> 01, wins_l += 1.
//   - else -> 10, wins_r += 1.
//   - Wins saturate at WINS_TO_MATCH; round_over = 1.
//  ROUND_END + round_start:
//   - Health = MAX_HEALTH, ko_show = 0, round_over = 0, winner = 00 -> READY.
//   - If match_over: wins and match_over also clear.
//  Reset mid-round: any state, next cycle equals the post-reset values above; in-flight hits are discarded.
//  Outputs: all registered; no combinational paths from inputs to outputs.
// STRUCTURE
//  Shared include status_bar_defs.vh:
//   - state encodings (READY, FIGHT, DRAIN, KO_FLASH, ROUND_END)
//   - WIN_NONE/L/R/DRAW codes
//   - default MAX_HEALTH
//  One sub-module: anim_tick_gen (TICK_DIV counter, clk + reset -> tick pulse), reused by the renderer.
// TESTING (TICK_DIV=4, DRAIN_MAX_TICKS=5, KO_FLASH_TICKS=3, MAX_HEALTH=300)
//  1. reset; round_start; hit_r dmg 50 -> next cycle curr_health_r = 250, hit_accept_r = 1 for 1 cycle.
//  2. FIGHT, r = 30; hit_r dmg 100 -> curr_health_r = 0, DRAIN, freeze = 1.
//     Then set final_health_r = 0 -> KO_FLASH; ko_show toggles 3 ticks.
//     Then round_over = 1, winner = 01, wins_l = 1.
//  3. l = r = 10; hit_l dmg 10 and hit_r dmg 10 same cycle -> both 0, both accepts.
//     Ends with winner = 11, wins unchanged.
//  4. DRAIN with final_health never matching -> KO_FLASH after exactly 5 ticks.
//  5. hit_l in READY, DRAIN and ROUND_END -> no health change, no accept.
//     round_start in FIGHT -> ignored.
//  6. Reset asserted mid-KO_FLASH -> next cycle READY, health 300, ko_show 0, wins 0.
//     Also: wins_r reaching 2 -> match_over = 1; round_start -> wins clear.

Source files
------------

// File: rtl/round_ko_sequencer_pkg.sv
// Shared definitions for the round/KO sequencer and the status-bar renderer:
// state encodings, winner codes, default health and saturating damage helper.
package round_ko_sequencer_pkg;

  typedef logic [8:0] health_t;

  localparam logic [2:0] ST_READY     = 3'd0;
  localparam logic [2:0] ST_FIGHT     = 3'd1;
  localparam logic [2:0] ST_DRAIN     = 3'd2;
  localparam logic [2:0] ST_KO_FLASH  = 3'd3;
  localparam logic [2:0] ST_ROUND_END = 3'd4;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_L    = 2'b01;
  localparam logic [1:0] WIN_R    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam health_t DEFAULT_MAX_HEALTH = 9'd300;

  // Damage at or above the remaining health floors it at zero.
  function automatic health_t sat_sub(input health_t h, input health_t d);
    return (d >= h) ? '0 : health_t'(h - d);
  endfunction

endpackage

// File: rtl/round_ko_sequencer_anim_tick_gen.sv
// Animation tick generator: free-running 0..TICK_DIV-1 counter, one-cycle tick
// at the terminal count. Also used by the status-bar renderer.
module anim_tick_gen #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(TICK_DIV - 1));
  assign tick   = w_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/round_ko_sequencer.sv
// Round sequencer: owns both fighters' health, accepts hits during FIGHT, waits
// for the status bars to finish draining, flashes the KO banner and tallies wins.
module round_ko_sequencer
  import round_ko_sequencer_pkg::*;
#(
  parameter health_t    MAX_HEALTH      = DEFAULT_MAX_HEALTH,
  parameter int         TICK_DIV        = 5_000_000,
  parameter int         DRAIN_MAX_TICKS = 40,
  parameter int         KO_FLASH_TICKS  = 20,
  parameter logic [1:0] WINS_TO_MATCH   = 2'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       round_start,
  input  logic       hit_l,
  input  logic [8:0] hit_dmg_l,
  input  logic       hit_r,
  input  logic [8:0] hit_dmg_r,
  input  logic [8:0] final_health_l,
  input  logic [8:0] final_health_r,
  output logic [8:0] curr_health_l,
  output logic [8:0] curr_health_r,
  output logic       hit_accept_l,
  output logic       hit_accept_r,
  output logic       freeze,
  output logic       ko_show,
  output logic       round_over,
  output logic [1:0] winner,
  output logic [1:0] wins_l,
  output logic [1:0] wins_r,
  output logic       match_over
);

  localparam int TMAX = (DRAIN_MAX_TICKS > KO_FLASH_TICKS) ? DRAIN_MAX_TICKS : KO_FLASH_TICKS;
  localparam int TCW  = $clog2(TMAX + 1);

  logic [2:0]     r_state;
  health_t        r_health_l;
  health_t        r_health_r;
  logic           r_accept_l;
  logic           r_accept_r;
  logic           r_freeze;
  logic           r_ko_show;
  logic           r_round_over;
  logic [1:0]     r_winner;
  logic [1:0]     r_wins_l;
  logic [1:0]     r_wins_r;
  logic           r_match_over;
  logic [TCW-1:0] r_tick_cnt;

  logic       w_tick;
  logic       w_drain_match;
  logic       w_drain_last;
  logic       w_flash_last;
  logic [1:0] w_winner;
  logic [1:0] w_wins_l_next;
  logic [1:0] w_wins_r_next;

  anim_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_drain_match = (final_health_l == r_health_l) && (final_health_r == r_health_r);
  assign w_drain_last  = w_tick && (r_tick_cnt == TCW'(DRAIN_MAX_TICKS - 1));
  assign w_flash_last  = w_tick && (r_tick_cnt == TCW'(KO_FLASH_TICKS - 1));

  // Outcome of the round as it stands; only latched on the way into ROUND_END.
  always_comb begin
    w_winner      = WIN_R;
    w_wins_l_next = r_wins_l;
    w_wins_r_next = r_wins_r;
    if (r_health_l == '0 && r_health_r == '0) begin
      w_winner = WIN_DRAW;
    end else if (r_health_r == '0) begin
      w_winner = WIN_L;
    end
    if (w_winner == WIN_L && r_wins_l != WINS_TO_MATCH) begin
      w_wins_l_next = r_wins_l + 2'd1;
    end
    if (w_winner == WIN_R && r_wins_r != WINS_TO_MATCH) begin
      w_wins_r_next = r_wins_r + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_READY;
      r_health_l   <= MAX_HEALTH;
      r_health_r   <= MAX_HEALTH;
      r_accept_l   <= 1'b0;
      r_accept_r   <= 1'b0;
      r_freeze     <= 1'b1;
      r_ko_show    <= 1'b0;
      r_round_over <= 1'b0;
      r_winner     <= WIN_NONE;
      r_wins_l     <= 2'd0;
      r_wins_r     <= 2'd0;
      r_match_over <= 1'b0;
      r_tick_cnt   <= '0;
    end else begin
      r_accept_l <= 1'b0;
      r_accept_r <= 1'b0;
      case (r_state)
        ST_READY: begin
          if (round_start) begin
            r_state  <= ST_FIGHT;
            r_freeze <= 1'b0;
          end
        end
        ST_FIGHT: begin
          if (hit_l) begin
            r_health_l <= sat_sub(r_health_l, hit_dmg_l);
            r_accept_l <= 1'b1;
          end
          if (hit_r) begin
            r_health_r <= sat_sub(r_health_r, hit_dmg_r);
            r_accept_r <= 1'b1;
          end
          // KO is judged on the already-updated health, one cycle after the hit.
          if (r_health_l == '0 || r_health_r == '0) begin
            r_state    <= ST_DRAIN;
            r_freeze   <= 1'b1;
            r_tick_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (w_drain_match || w_drain_last) begin
            r_state    <= ST_KO_FLASH;
            r_tick_cnt <= '0;
            r_ko_show  <= 1'b1;
          end else if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        ST_KO_FLASH: begin
          if (w_flash_last) begin
            r_state      <= ST_ROUND_END;
            r_ko_show    <= 1'b1;
            r_round_over <= 1'b1;
            r_winner     <= w_winner;
            r_wins_l     <= w_wins_l_next;
            r_wins_r     <= w_wins_r_next;
            r_match_over <= (w_wins_l_next == WINS_TO_MATCH) || (w_wins_r_next == WINS_TO_MATCH);
            r_tick_cnt   <= '0;
          end else if (w_tick) begin
            r_ko_show  <= ~r_ko_show;
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        ST_ROUND_END: begin
          if (round_start) begin
            r_state      <= ST_READY;
            r_health_l   <= MAX_HEALTH;
            r_health_r   <= MAX_HEALTH;
            r_ko_show    <= 1'b0;
            r_round_over <= 1'b0;
            r_winner     <= WIN_NONE;
            if (r_match_over) begin
              r_wins_l     <= 2'd0;
              r_wins_r     <= 2'd0;
              r_match_over <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_READY;
        end
      endcase
    end
  end

  assign curr_health_l = r_health_l;
  assign curr_health_r = r_health_r;
  assign hit_accept_l  = r_accept_l;
  assign hit_accept_r  = r_accept_r;
  assign freeze        = r_freeze;
  assign ko_show       = r_ko_show;
  assign round_over    = r_round_over;
  assign winner        = r_winner;
  assign wins_l        = r_wins_l;
  assign wins_r        = r_wins_r;
  assign match_over    = r_match_over;

endmodule

// File: tb/tb_round_ko_sequencer.sv
// Directed bench for round_ko_sequencer with short ticks (TICK_DIV=4,
// DRAIN_MAX_TICKS=5, KO_FLASH_TICKS=3); expected values are hand-computed.
module tb_round_ko_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       round_start;
  logic       hit_l;
  logic [8:0] hit_dmg_l;
  logic       hit_r;
  logic [8:0] hit_dmg_r;
  logic [8:0] final_health_l;
  logic [8:0] final_health_r;
  logic [8:0] curr_health_l;
  logic [8:0] curr_health_r;
  logic       hit_accept_l;
  logic       hit_accept_r;
  logic       freeze;
  logic       ko_show;
  logic       round_over;
  logic [1:0] winner;
  logic [1:0] wins_l;
  logic [1:0] wins_r;
  logic       match_over;

  int n_checks = 0;
  int n_fail   = 0;

  // Phase of the 4-cycle tick: the edge taken while ph==3 carries a tick.
  logic [1:0] ph;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) ph <= 2'd0;
    else       ph <= ph + 2'd1;
  end

  round_ko_sequencer #(
    .MAX_HEALTH      (9'd300),
    .TICK_DIV        (4),
    .DRAIN_MAX_TICKS (5),
    .KO_FLASH_TICKS  (3),
    .WINS_TO_MATCH   (2'd2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .round_start    (round_start),
    .hit_l          (hit_l),
    .hit_dmg_l      (hit_dmg_l),
    .hit_r          (hit_r),
    .hit_dmg_r      (hit_dmg_r),
    .final_health_l (final_health_l),
    .final_health_r (final_health_r),
    .curr_health_l  (curr_health_l),
    .curr_health_r  (curr_health_r),
    .hit_accept_l   (hit_accept_l),
    .hit_accept_r   (hit_accept_r),
    .freeze         (freeze),
    .ko_show        (ko_show),
    .round_over     (round_over),
    .winner         (winner),
    .wins_l         (wins_l),
    .wins_r         (wins_r),
    .match_over     (match_over)
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    round_start = 1'b1;
    step();
    round_start = 1'b0;
    $display("round_start: freeze=%0d round_over=%0d wins=%0d/%0d", freeze, round_over, wins_l, wins_r);
  endtask

  task automatic hit(input logic l, input logic [8:0] dl, input logic r, input logic [8:0] dr);
    hit_l = l; hit_dmg_l = dl;
    hit_r = r; hit_dmg_r = dr;
    step();
    hit_l = 1'b0; hit_r = 1'b0;
    $display("hit l=%0d/%0d r=%0d/%0d -> health %0d/%0d accept %0d/%0d",
             l, dl, r, dr, curr_health_l, curr_health_r, hit_accept_l, hit_accept_r);
  endtask

  // Called right after KO_FLASH entry; walks the three flash ticks into ROUND_END.
  task automatic run_flash();
    int nt;
    bit was_tick;
    nt = 0;
    for (int i = 0; i < 20 && nt < 3; i++) begin
      was_tick = (ph == 2'd3);
      step();
      if (was_tick) begin
        nt++;
        if (nt < 3) begin
          check("flash_ko_toggle", ko_show, (nt == 2) ? 1 : 0);
          check("flash_round_over_low", round_over, 0);
        end else begin
          check("flash_end_round_over", round_over, 1);
          check("flash_end_ko_steady", ko_show, 1);
        end
      end
    end
    check("flash_tick_count", nt, 3);
    $display("round end: winner=%0d wins=%0d/%0d match_over=%0d", winner, wins_l, wins_r, match_over);
  endtask

  initial begin
    int  nt;
    bit  was_tick;

    reset = 1'b1; round_start = 1'b0;
    hit_l = 1'b0; hit_dmg_l = '0; hit_r = 1'b0; hit_dmg_r = '0;
    final_health_l = 9'd300; final_health_r = 9'd300;
    step(); step();
    check("rst_health_l", curr_health_l, 300);
    check("rst_health_r", curr_health_r, 300);
    check("rst_freeze", freeze, 1);
    check("rst_ko_show", ko_show, 0);
    check("rst_round_over", round_over, 0);
    check("rst_winner", winner, 0);
    check("rst_wins", {wins_l, wins_r}, 0);
    check("rst_match_over", match_over, 0);
    check("rst_accepts", {hit_accept_l, hit_accept_r}, 0);
    reset = 1'b0;

    // 1: first hit on the right fighter
    start_pulse();
    check("fight_freeze", freeze, 0);
    hit(1'b0, 9'd0, 1'b1, 9'd50);
    check("t1_health_r", curr_health_r, 250);
    check("t1_accept_r", hit_accept_r, 1);
    check("t1_accept_l", hit_accept_l, 0);
    check("t1_health_l", curr_health_l, 300);
    step();
    check("t1_accept_r_pulse", hit_accept_r, 0);

    // round_start in FIGHT ignored; zero damage accepted with no change
    start_pulse();
    check("rs_in_fight_freeze", freeze, 0);
    hit(1'b1, 9'd0, 1'b0, 9'd0);
    check("dmg0_accept", hit_accept_l, 1);
    check("dmg0_health", curr_health_l, 300);

    // 2: right fighter knocked out, left wins
    hit(1'b0, 9'd0, 1'b1, 9'd220);
    check("t2_health_r30", curr_health_r, 30);
    hit(1'b0, 9'd0, 1'b1, 9'd100);
    check("t2_health_r_sat", curr_health_r, 0);
    check("t2_freeze_still_fight", freeze, 0);
    final_health_r = 9'd30;
    step();
    check("t2_drain_freeze", freeze, 1);
    check("t2_drain_ko", ko_show, 0);
    hit(1'b1, 9'd5, 1'b0, 9'd0);
    check("drain_hit_health", curr_health_l, 300);
    check("drain_hit_accept", hit_accept_l, 0);
    final_health_r = 9'd0;
    step();
    check("t2_ko_entry", ko_show, 1);
    run_flash();
    check("t2_winner", winner, 1);
    check("t2_wins_l", wins_l, 1);
    check("t2_wins_r", wins_r, 0);
    check("t2_match_over", match_over, 0);
    hit(1'b1, 9'd5, 1'b0, 9'd0);
    check("rend_hit_health", curr_health_l, 300);
    check("rend_hit_accept", hit_accept_l, 0);

    // 3: simultaneous hits, double KO
    start_pulse();
    check("t3_ready_round_over", round_over, 0);
    check("t3_ready_winner", winner, 0);
    check("t3_ready_ko", ko_show, 0);
    check("t3_ready_health_r", curr_health_r, 300);
    check("t3_ready_freeze", freeze, 1);
    hit(1'b1, 9'd5, 1'b0, 9'd0);
    check("ready_hit_health", curr_health_l, 300);
    check("ready_hit_accept", hit_accept_l, 0);
    start_pulse();
    hit(1'b1, 9'd290, 1'b1, 9'd290);
    check("t3_both_10", {curr_health_l, curr_health_r}, {9'd10, 9'd10});
    hit(1'b1, 9'd10, 1'b1, 9'd10);
    check("t3_both_0", {curr_health_l, curr_health_r}, 0);
    check("t3_both_accept", {hit_accept_l, hit_accept_r}, 3);
    final_health_l = 9'd0; final_health_r = 9'd0;
    step();
    check("t3_drain_freeze", freeze, 1);
    step();
    check("t3_ko_entry", ko_show, 1);
    run_flash();
    check("t3_winner_draw", winner, 3);
    check("t3_wins", {wins_l, wins_r}, {2'd1, 2'd0});

    // 4: drain never matches, timeout after exactly 5 ticks; right wins
    start_pulse();
    start_pulse();
    final_health_l = 9'd77; final_health_r = 9'd300;
    hit(1'b1, 9'd300, 1'b0, 9'd0);
    check("t4_health_l", curr_health_l, 0);
    step();
    check("t4_drain_freeze", freeze, 1);
    nt = 0;
    for (int i = 0; i < 40; i++) begin
      was_tick = (ph == 2'd3);
      step();
      if (was_tick) nt++;
      if (ko_show) break;
    end
    check("t4_drain_timeout_ticks", nt, 5);
    check("t4_exit_on_tick", was_tick, 1);
    run_flash();
    check("t4_winner", winner, 2);
    check("t4_wins_r", wins_r, 1);

    // 6a: right reaches two wins -> match over, then cleared by round_start
    start_pulse();
    start_pulse();
    final_health_l = 9'd0; final_health_r = 9'd300;
    hit(1'b1, 9'd300, 1'b0, 9'd0);
    step();
    step();
    check("t6_ko_entry", ko_show, 1);
    run_flash();
    check("t6_wins_r2", wins_r, 2);
    check("t6_wins_l1", wins_l, 1);
    check("t6_match_over", match_over, 1);
    start_pulse();
    check("t6_wins_clear", {wins_l, wins_r}, 0);
    check("t6_match_clear", match_over, 0);

    // 6b: left wins one, then reset during KO_FLASH
    start_pulse();
    final_health_l = 9'd300; final_health_r = 9'd0;
    hit(1'b0, 9'd0, 1'b1, 9'd300);
    step();
    step();
    run_flash();
    check("t6b_wins_l", wins_l, 1);
    start_pulse();
    start_pulse();
    hit(1'b0, 9'd0, 1'b1, 9'd300);
    step();
    step();
    check("t6b_ko_entry", ko_show, 1);
    step();
    reset = 1'b1; hit_l = 1'b1; hit_dmg_l = 9'd40;
    step();
    reset = 1'b0; hit_l = 1'b0;
    $display("reset mid-KO: health %0d/%0d ko=%0d wins=%0d/%0d", curr_health_l, curr_health_r, ko_show, wins_l, wins_r);
    check("mid_rst_ko", ko_show, 0);
    check("mid_rst_health", {curr_health_l, curr_health_r}, {9'd300, 9'd300});
    check("mid_rst_wins", {wins_l, wins_r}, 0);
    check("mid_rst_freeze", freeze, 1);
    check("mid_rst_round_over", round_over, 0);
    check("mid_rst_accept", hit_accept_l, 0);
    start_pulse();
    check("mid_rst_ready_to_fight", freeze, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
